// File: rtl/artec_dma_pkg.sv
// Shared types and defaults for the DMA weighted round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state enum, default parameter values, the
// channel-indexed weight/level vector typedefs sized from the defaults,
// and a wrap-around index helper.
package artec_dma_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_REQ_W    = 16;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_AGE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    // Per-channel weight vector and per-channel level/threshold vector.
    typedef logic [DEF_NUM_CH-1:0][DEF_WEIGHT_W-1:0] weight_vec_t;
    typedef logic [DEF_NUM_CH-1:0][DEF_REQ_W-1:0]    level_vec_t;

    // Next index after idx in a ring of n entries.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/artec_dma_rr_pick.sv
// Masked find-first starting at start_i and wrapping around N entries.
// Latency: purely combinational.
// Backpressure: none (no state).
//
// Ports: mask_i  - candidate set
//        start_i - first index examined (search order start_i, start_i+1, ... wrapping)
//        idx_o   - first set index in search order (0 when none)
//        found_o - at least one mask bit set
module artec_dma_rr_pick #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    // One extra bit so start + offset never overflows before the wrap.
    logic [IW:0] pos;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start_i} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found_o && mask_i[pos[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/artec_dma_arb_wrr.sv
// Weighted round-robin DMA channel arbiter with a threshold/starvation high class.
// Latency: eligible request in cycle N gives grant_valid_o in cycle N+1.
// Backpressure: grant held stable until grant_ready_i; arbiter then waits for done_i.
//
// Ports: clk, rstn (async active-low), clear (sync clear of all state)
//        req_i/ch_en_i/weight_i/prio_thr_i/age_thr_i - per-channel request configuration
//        grant_o/grant_valid_o/grant_prio_o, grant_ready_i - grant handshake
//        done_i - granted transfer finished
// Build option: define ARTEC_DMA_ARB_STARVE_EN to add per-channel age counters that
// promote starved channels into the high class once age reaches age_thr_i.
module artec_dma_arb_wrr
    import artec_dma_pkg::*;
#(
    parameter int  NUM_CH   = DEF_NUM_CH,
    parameter int  REQ_W    = DEF_REQ_W,
    parameter int  WEIGHT_W = DEF_WEIGHT_W,
    parameter int  AGE_W    = DEF_AGE_W,
    localparam int IDX_W    = $clog2(NUM_CH)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             clear,
    input  logic [NUM_CH-1:0][REQ_W-1:0]     req_i,
    input  logic [NUM_CH-1:0]                ch_en_i,
    input  logic [NUM_CH-1:0][WEIGHT_W-1:0]  weight_i,
    input  logic [NUM_CH-1:0][REQ_W-1:0]     prio_thr_i,
    input  logic [AGE_W-1:0]                 age_thr_i,
    output logic [IDX_W-1:0]                 grant_o,
    output logic                             grant_valid_o,
    output logic                             grant_prio_o,
    input  logic                             grant_ready_i,
    input  logic                             done_i
);

    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_CH - 1);

    arb_state_e                          state_q, state_d;
    logic [IDX_W-1:0]                    grant_q, grant_d;
    logic                                prio_q, prio_d;
    logic [IDX_W-1:0]                    ptr_q, ptr_d;
    logic [NUM_CH-1:0][WEIGHT_W-1:0]     credit_q, credit_d;
`ifdef ARTEC_DMA_ARB_STARVE_EN
    logic [NUM_CH-1:0][AGE_W-1:0]        age_q, age_d;
`else
    logic                                unused_age_thr;
    assign unused_age_thr = ^age_thr_i;
`endif

    logic [NUM_CH-1:0] elig_c;
    logic [NUM_CH-1:0] high_c;
    logic [IDX_W-1:0]  start_c;
    logic [IDX_W-1:0]  high_idx, elig_idx;
    logic              high_found, elig_found;
    logic [IDX_W-1:0]  win_idx;
    logic              win_prio;

    // Eligibility and high-class membership from the live inputs.
    always_comb begin
        elig_c = '0;
        high_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig_c[i] = ch_en_i[i] && (req_i[i] != '0);
            high_c[i] = elig_c[i] && (prio_thr_i[i] != '0) && (req_i[i] >= prio_thr_i[i]);
`ifdef ARTEC_DMA_ARB_STARVE_EN
            if (elig_c[i] && (age_thr_i != '0) && (age_q[i] >= age_thr_i)) begin
                high_c[i] = 1'b1;
            end
`endif
        end
    end

    // Both searches begin just after the pointer, so the pointer channel is examined last.
    assign start_c = (ptr_q == PTR_RST) ? '0 : ptr_q + 1'b1;

    artec_dma_rr_pick #(.N(NUM_CH)) u_pick_high (
        .mask_i  (high_c),
        .start_i (start_c),
        .idx_o   (high_idx),
        .found_o (high_found)
    );

    artec_dma_rr_pick #(.N(NUM_CH)) u_pick_elig (
        .mask_i  (elig_c),
        .start_i (start_c),
        .idx_o   (elig_idx),
        .found_o (elig_found)
    );

    // High class ignores credits; otherwise the pointer channel keeps its turn
    // while it still holds credit.
    always_comb begin
        win_prio = 1'b0;
        win_idx  = elig_idx;
        if (high_found) begin
            win_prio = 1'b1;
            win_idx  = high_idx;
        end else if (elig_c[ptr_q] && (credit_q[ptr_q] != '0)) begin
            win_idx  = ptr_q;
        end
    end

    // Credit bookkeeping for the channel currently granted. A zero credit means
    // the channel starts a fresh turn and loads max(weight,1)-1.
    logic [WEIGHT_W-1:0] w_eff, cur_credit, new_credit;

    always_comb begin
        cur_credit = credit_q[grant_q];
        w_eff      = (weight_i[grant_q] == '0) ? WEIGHT_W'(1) : weight_i[grant_q];
        new_credit = (cur_credit != '0) ? cur_credit - 1'b1 : w_eff - 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        prio_d   = prio_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
`ifdef ARTEC_DMA_ARB_STARVE_EN
        age_d    = age_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (elig_found) begin
                    state_d = ST_GRANT;
                    grant_d = win_idx;
                    prio_d  = win_prio;
                end
            end
            ST_GRANT: begin
                if (grant_ready_i) begin
                    state_d           = done_i ? ST_IDLE : ST_BUSY;
                    credit_d[grant_q] = new_credit;
                    // Turn exhausted, or a high-class grant: rotate past this channel.
                    if ((new_credit == '0) || prio_q) begin
                        ptr_d = grant_q;
                    end
`ifdef ARTEC_DMA_ARB_STARVE_EN
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (IDX_W'(i) == grant_q) begin
                            age_d[i] = '0;
                        end else if (elig_c[i] && (age_q[i] != '1)) begin
                            age_d[i] = age_q[i] + 1'b1;
                        end
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            prio_d   = 1'b0;
            ptr_d    = PTR_RST;
            credit_d = '0;
`ifdef ARTEC_DMA_ARB_STARVE_EN
            age_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            prio_q   <= 1'b0;
            ptr_q    <= PTR_RST;
            credit_q <= '0;
`ifdef ARTEC_DMA_ARB_STARVE_EN
            age_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            prio_q   <= prio_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
`ifdef ARTEC_DMA_ARB_STARVE_EN
            age_q    <= age_d;
`endif
        end
    end

    assign grant_o       = grant_q;
    assign grant_prio_o  = prio_q;
    assign grant_valid_o = (state_q == ST_GRANT);

endmodule
